// File: rtl/mem_stage_lsu.sv
`timescale 1ns/1ps
// Memory-stage load/store unit: req/ack bus initiator with byte-lane alignment and watchdog abort.
// Optional MISALIGN_TRAP_EN traps misaligned half/word accesses without issuing a bus cycle.
module mem_stage_lsu #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_mem_rd,
  input  logic              i_mem_wr,
  input  logic [XLEN/8-1:0] i_byte_sel,
  input  logic              i_unsigned,
  input  logic [XLEN-1:0]   i_addr,
  input  logic [XLEN-1:0]   i_wdata,
  output logic              o_stall,
  output logic [XLEN-1:0]   o_rdata,
  output logic              o_rdata_vld,
  output logic              o_err,
  output logic              o_bus_req,
  output logic              o_bus_we,
  output logic [XLEN-1:0]   o_bus_addr,
  output logic [XLEN/8-1:0] o_bus_be,
  output logic [XLEN-1:0]   o_bus_wdata,
  input  logic              i_bus_ack,
  input  logic [XLEN-1:0]   i_bus_rdata,
  input  logic              i_bus_err
);
  localparam int unsigned   NB      = XLEN / 8;
  localparam int unsigned   CW      = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WD_LAST = CW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [NB-1:0]   be_q, be_d, sel_q, sel_d;
  logic [1:0]      off_q, off_d;
  logic            we_q, we_d, ld_q, ld_d, uns_q, uns_d, err_q, err_d;
  logic [CW-1:0]   wd_q, wd_d;
  logic            req_in, misal;
  logic [XLEN-1:0] shifted, ld_ext;

  assign req_in = i_mem_rd | i_mem_wr;

`ifdef MISALIGN_TRAP_EN
  assign misal = ((i_byte_sel == NB'(4'b0011)) & i_addr[0]) |
                 ((i_byte_sel == NB'(4'b1111)) & (|i_addr[1:0]));
`else
  assign misal = 1'b0;
`endif

  // Unrecognised size masks fall through to a full-word load
  always_comb begin
    shifted = i_bus_rdata >> {off_q, 3'b000};
    ld_ext  = shifted;
    if (sel_q == NB'(4'b0001))
      ld_ext = {{(XLEN-8){~uns_q & shifted[7]}}, shifted[7:0]};
    else if (sel_q == NB'(4'b0011))
      ld_ext = {{(XLEN-16){~uns_q & shifted[15]}}, shifted[15:0]};
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    be_d    = be_q;
    sel_d   = sel_q;
    off_d   = off_q;
    we_d    = we_q;
    ld_d    = ld_q;
    uns_d   = uns_q;
    err_d   = err_q;
    wd_d    = wd_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_in) begin
          addr_d  = {i_addr[XLEN-1:2], 2'b00};
          be_d    = i_byte_sel << i_addr[1:0];
          wdata_d = i_wdata << {i_addr[1:0], 3'b000};
          sel_d   = i_byte_sel;
          off_d   = i_addr[1:0];
          uns_d   = i_unsigned;
          we_d    = i_mem_wr;
          ld_d    = i_mem_rd & ~i_mem_wr;
          err_d   = i_mem_rd & i_mem_wr;
          wd_d    = '0;
          state_d = S_REQ;
          if (misal) begin
            ld_d    = 1'b0;
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_REQ: begin
        if (i_bus_ack) begin
          state_d = S_DONE;
          err_d   = err_q | i_bus_err;
          if (ld_q) rdata_d = i_bus_err ? '0 : ld_ext;
        end else if (wd_q == WD_LAST) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          if (ld_q) rdata_d = '0;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q    <= '0;
      sel_q   <= '0;
      off_q   <= '0;
      we_q    <= 1'b0;
      ld_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      be_q    <= be_d;
      sel_q   <= sel_d;
      off_q   <= off_d;
      we_q    <= we_d;
      ld_q    <= ld_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
    end
  end

  // Stall is gated by reset so it drops at once even with a request still presented
  assign o_stall     = i_rstn & ((state_q == S_REQ) | ((state_q == S_IDLE) & req_in));
  assign o_bus_req   = (state_q == S_REQ);
  assign o_bus_we    = we_q;
  assign o_bus_addr  = addr_q;
  assign o_bus_be    = be_q;
  assign o_bus_wdata = wdata_q;
  assign o_rdata     = rdata_q;
  assign o_rdata_vld = (state_q == S_DONE) & ld_q;
  assign o_err       = (state_q == S_DONE) & err_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
`timescale 1ns/1ps
// Randomised self-checking bench for mem_stage_lsu against a behavioural transaction model.
module tb_mem_stage_lsu;
  localparam int unsigned MW = 4;

  logic        i_clk = 1'b0, i_rstn = 1'b0;
  logic        i_mem_rd = 1'b0, i_mem_wr = 1'b0, i_unsigned = 1'b0;
  logic [3:0]  i_byte_sel = '0;
  logic [31:0] i_addr = '0, i_wdata = '0;
  logic        o_stall, o_rdata_vld, o_err, o_bus_req, o_bus_we;
  logic [31:0] o_rdata, o_bus_addr, o_bus_wdata;
  logic [3:0]  o_bus_be;
  logic        i_bus_ack = 1'b0, i_bus_err = 1'b0;
  logic [31:0] i_bus_rdata = '0;

  always #5 i_clk = ~i_clk;

  mem_stage_lsu #(.XLEN(32), .MAX_WAIT(MW)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_mem_rd(i_mem_rd), .i_mem_wr(i_mem_wr),
    .i_byte_sel(i_byte_sel), .i_unsigned(i_unsigned), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_stall(o_stall), .o_rdata(o_rdata), .o_rdata_vld(o_rdata_vld), .o_err(o_err),
    .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr), .o_bus_be(o_bus_be),
    .o_bus_wdata(o_bus_wdata), .i_bus_ack(i_bus_ack), .i_bus_rdata(i_bus_rdata), .i_bus_err(i_bus_err)
  );

  int unsigned n_chk = 0, n_pass = 0;
  logic [31:0] last_rdata = '0;

  typedef struct {
    int          stall, req, vld, err;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr, wdata, rdata;
    bit          done;
  } obs_t;

  // Reference: load value from bus word by offset/size/sign rules
  function automatic logic [31:0] ref_load(logic [31:0] bus, int off, logic [3:0] sel, bit uns);
    logic [31:0] v;
    v = bus >> (8 * off);
    if (sel == 4'b0001) begin
      v = v % 256;
      if (!uns && v >= 128) v = v + 32'hFFFFFF00;
    end else if (sel == 4'b0011) begin
      v = v % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF0000;
    end
    return v;
  endfunction

  function automatic logic [3:0] ref_be(logic [3:0] sel, int off);
    logic [3:0] r;
    r = '0;
    for (int b = 0; b < 4; b++)
      if (sel[b] && (b + off) < 4) r[b + off] = 1'b1;
    return r;
  endfunction

  function automatic bit ref_misal(logic [3:0] sel, int off);
`ifdef MISALIGN_TRAP_EN
    return (sel == 4'b0011 && (off % 2) == 1) || (sel == 4'b1111 && off != 0);
`else
    return 1'b0;
`endif
  endfunction

  // Drives one access, answers the bus after ack_after REQ cycles (0 = never), records observations
  task automatic run_access(input bit rd, input bit wr, input logic [3:0] sel, input bit uns,
                            input logic [31:0] addr, input logic [31:0] wdata, input int ack_after,
                            input logic [31:0] brdata, input bit berr, output obs_t o);
    o = '{stall: 0, req: 0, vld: 0, err: 0, we: 1'b0, be: '0, addr: '0, wdata: '0, rdata: '0, done: 1'b0};
    i_mem_rd = rd; i_mem_wr = wr; i_byte_sel = sel; i_unsigned = uns; i_addr = addr; i_wdata = wdata;
    for (int c = 0; c < 60; c++) begin
      @(negedge i_clk);
      i_bus_ack = 1'b0; i_bus_err = 1'b0; i_bus_rdata = '0;
      if (o_rdata_vld) o.vld++;
      if (o_err) o.err++;
      if (o_bus_req) begin
        o.req++;
        o.be = o_bus_be; o.addr = o_bus_addr; o.wdata = o_bus_wdata; o.we = o_bus_we;
        if (o.req == ack_after) begin
          i_bus_ack = 1'b1; i_bus_err = berr; i_bus_rdata = brdata;
        end
      end
      if (o_stall) o.stall++;
      else begin
        o.rdata = o_rdata; o.done = 1'b1;
        break;
      end
    end
    @(posedge i_clk); #1;
    i_mem_rd = 1'b0; i_mem_wr = 1'b0;
  endtask

  task automatic test_reset();
    i_rstn = 1'b0;
    #12;
    n_chk++;
    if ({o_bus_req, o_stall, o_rdata_vld, o_err, o_bus_we} !== 5'b0)
      $display("FAIL reset_ctrl: got %b want 00000", {o_bus_req, o_stall, o_rdata_vld, o_err, o_bus_we});
    else n_pass++;
    n_chk++;
    if ({o_rdata, o_bus_addr, o_bus_wdata, o_bus_be} !== '0)
      $display("FAIL reset_data: rdata=%h addr=%h wdata=%h be=%b want all 0", o_rdata, o_bus_addr, o_bus_wdata, o_bus_be);
    else n_pass++;
    @(negedge i_clk); i_rstn = 1'b1;
    @(posedge i_clk); #1;
    last_rdata = '0;
  endtask

  task automatic test_store();
    obs_t o;
    run_access(1'b0, 1'b1, 4'b1111, 1'b0, 32'h104, 32'hDEADBEEF, 3, '0, 1'b0, o);
    n_chk++;
    if (!o.done || o.stall != 4 || o.req != 3)
      $display("FAIL sw_timing: done=%0d stall=%0d req=%0d want 1/4/3", o.done, o.stall, o.req);
    else n_pass++;
    n_chk++;
    if ({o.we, o.be, o.addr, o.wdata} !== {1'b1, 4'b1111, 32'h104, 32'hDEADBEEF})
      $display("FAIL sw_bus: we=%b be=%b addr=%h wdata=%h want 1 1111 00000104 deadbeef", o.we, o.be, o.addr, o.wdata);
    else n_pass++;
    n_chk++;
    if (o.err != 0 || o.vld != 0) $display("FAIL sw_flags: err=%0d vld=%0d want 0/0", o.err, o.vld);
    else n_pass++;
    run_access(1'b0, 1'b1, 4'b0001, 1'b0, 32'h203, 32'h000000A5, 1, '0, 1'b0, o);
    n_chk++;
    if ({o.be, o.addr, o.wdata} !== {4'b1000, 32'h200, 32'hA5000000} || o.stall != 2)
      $display("FAIL sb_bus: be=%b addr=%h wdata=%h stall=%0d want 1000 00000200 a5000000 2", o.be, o.addr, o.wdata, o.stall);
    else n_pass++;
  endtask

  task automatic test_load_ext();
    obs_t o;
    logic [31:0] exp_v [3];
    exp_v[0] = 32'hFFFFFFF4; exp_v[1] = 32'h000000F4; exp_v[2] = 32'h000012F4;
    for (int k = 0; k < 3; k++) begin
      run_access(1'b1, 1'b0, (k == 2) ? 4'b0011 : 4'b0001, k == 1, 32'h302, '0, 2, 32'h12F45678, 1'b0, o);
      n_chk++;
      if (o.rdata !== exp_v[k] || o.vld != 1 || o.err != 0 || o.be !== ((k == 2) ? 4'b1100 : 4'b0100))
        $display("FAIL load_ext%0d: rdata=%h vld=%0d err=%0d be=%b want %h 1 0", k, o.rdata, o.vld, o.err, o.be, exp_v[k]);
      else n_pass++;
    end
    last_rdata = exp_v[2];
  endtask

  task automatic test_watchdog();
    obs_t o;
    run_access(1'b1, 1'b0, 4'b1111, 1'b0, 32'h500, '0, 0, '0, 1'b0, o);
    n_chk++;
    if (!o.done || o.req != MW || o.stall != MW + 1 || o.err != 1 || o.rdata !== 32'h0)
      $display("FAIL watchdog: done=%0d req=%0d stall=%0d err=%0d rdata=%h want 1 %0d %0d 1 0",
               o.done, o.req, o.stall, o.err, o.rdata, MW, MW + 1);
    else n_pass++;
    last_rdata = '0;
  endtask

  task automatic test_conflict_and_buserr();
    obs_t o;
    run_access(1'b1, 1'b0, 4'b1111, 1'b0, 32'h600, '0, 1, 32'h11223344, 1'b0, o);
    run_access(1'b1, 1'b1, 4'b1111, 1'b0, 32'h604, 32'h55AA55AA, 1, 32'h99999999, 1'b0, o);
    n_chk++;
    if (o.we !== 1'b1 || o.err != 1 || o.vld != 0 || o.rdata !== 32'h11223344)
      $display("FAIL rd_wr_conflict: we=%b err=%0d vld=%0d rdata=%h want 1 1 0 11223344", o.we, o.err, o.vld, o.rdata);
    else n_pass++;
    run_access(1'b1, 1'b0, 4'b1111, 1'b0, 32'h608, '0, 2, 32'h77777777, 1'b1, o);
    n_chk++;
    if (o.err != 1 || o.vld != 1 || o.rdata !== 32'h0)
      $display("FAIL bus_err_load: err=%0d vld=%0d rdata=%h want 1 1 0", o.err, o.vld, o.rdata);
    else n_pass++;
    last_rdata = '0;
  endtask

  task automatic test_async_reset();
    obs_t o;
    i_mem_rd = 1'b1; i_byte_sel = 4'b1111; i_addr = 32'h400; i_unsigned = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    n_chk++;
    if (o_bus_req !== 1'b1) $display("FAIL rst_pre_req: got %b want 1", o_bus_req);
    else n_pass++;
    #2 i_rstn = 1'b0;
    #1;
    n_chk++;
    if ({o_bus_req, o_stall} !== 2'b00) $display("FAIL rst_async_drop: req/stall=%b want 00", {o_bus_req, o_stall});
    else n_pass++;
    @(posedge i_clk); #1;
    i_mem_rd = 1'b0; i_rstn = 1'b1;
    last_rdata = '0;
    run_access(1'b1, 1'b0, 4'b1111, 1'b0, 32'h400, '0, 1, 32'hCAFEF00D, 1'b0, o);
    n_chk++;
    if (o.rdata !== 32'hCAFEF00D || o.vld != 1 || o.stall != 2 || o.err != 0)
      $display("FAIL rst_recover_lw: rdata=%h vld=%0d stall=%0d err=%0d want cafef00d 1 2 0", o.rdata, o.vld, o.stall, o.err);
    else n_pass++;
    last_rdata = 32'hCAFEF00D;
  endtask

  task automatic test_misalign();
    obs_t o;
    run_access(1'b1, 1'b0, 4'b1111, 1'b0, 32'h101, '0, 1, 32'h89ABCDEF, 1'b0, o);
`ifdef MISALIGN_TRAP_EN
    n_chk++;
    if (o.req != 0 || o.err != 1 || o.vld != 0 || o.stall != 1 || o.rdata !== last_rdata)
      $display("FAIL misalign_trap: req=%0d err=%0d vld=%0d stall=%0d rdata=%h want 0 1 0 1 %h",
               o.req, o.err, o.vld, o.stall, o.rdata, last_rdata);
    else n_pass++;
`else
    n_chk++;
    if (o.req != 1 || o.be !== 4'b1110 || o.err != 0 || o.rdata !== 32'h0089ABCD)
      $display("FAIL misalign_bus: req=%0d be=%b err=%0d rdata=%h want 1 1110 0 0089abcd", o.req, o.be, o.err, o.rdata);
    else n_pass++;
    last_rdata = 32'h0089ABCD;
`endif
  endtask

  task automatic test_back_to_back();
    obs_t o;
    for (int k = 0; k < 3; k++) begin
      run_access(1'b1, 1'b0, 4'b1111, 1'b0, 32'h700 + 4 * k, '0, 1, 32'h1000 + k, 1'b0, o);
      n_chk++;
      if (o.vld != 1 || o.stall != 2 || o.rdata !== 32'h1000 + k)
        $display("FAIL back_to_back%0d: vld=%0d stall=%0d rdata=%h want 1 2 %h", k, o.vld, o.stall, o.rdata, 32'h1000 + k);
      else n_pass++;
    end
    last_rdata = 32'h1002;
  endtask

  task automatic test_random();
    obs_t o;
    logic [3:0] sels [5];
    sels[0] = 4'b0001; sels[1] = 4'b0011; sels[2] = 4'b1111; sels[3] = 4'b0110; sels[4] = 4'b0001;
    for (int t = 0; t < 40; t++) begin
      int op, off, ack_after;
      bit rd, wr, uns, berr, trap, abort;
      logic [3:0] sel;
      logic [31:0] addr, wdata, brd;
      op = $urandom_range(0, 5);
      rd = (op < 3) || (op == 5);
      wr = (op >= 3);
      sel = sels[$urandom_range(0, 4)];
      uns = $urandom_range(0, 1);
      addr = $urandom; wdata = $urandom; brd = $urandom;
      off = addr % 4;
      ack_after = $urandom_range(0, 3);
      berr = ($urandom_range(0, 7) == 0);
      trap = ref_misal(sel, off);
      abort = (ack_after == 0);
      run_access(rd, wr, sel, uns, addr, wdata, ack_after, brd, berr, o);
      if (trap) begin
        n_chk++;
        if (o.req != 0 || o.stall != 1 || o.err != 1 || o.vld != 0)
          $display("FAIL rnd_trap%0d: req=%0d stall=%0d err=%0d vld=%0d want 0 1 1 0", t, o.req, o.stall, o.err, o.vld);
        else n_pass++;
      end else begin
        int exp_req;
        exp_req = abort ? MW : ack_after;
        if (rd && !wr) last_rdata = (abort || berr) ? 32'h0 : ref_load(brd, off, sel, uns);
        n_chk++;
        if (o.req != exp_req || o.stall != exp_req + 1)
          $display("FAIL rnd_timing%0d: req=%0d stall=%0d want %0d %0d", t, o.req, o.stall, exp_req, exp_req + 1);
        else n_pass++;
        n_chk++;
        if ({o.we, o.be, o.addr, o.wdata} !== {wr, ref_be(sel, off), addr - off, wdata << (8 * off)})
          $display("FAIL rnd_bus%0d: we=%b be=%b addr=%h wdata=%h want %b %b %h %h", t, o.we, o.be, o.addr, o.wdata,
                   wr, ref_be(sel, off), addr - off, wdata << (8 * off));
        else n_pass++;
        n_chk++;
        if (o.err != int'(abort || (!abort && berr) || (rd && wr)) || o.vld != int'(rd && !wr))
          $display("FAIL rnd_flags%0d: err=%0d vld=%0d want %0d %0d", t, o.err, o.vld,
                   int'(abort || berr || (rd && wr)), int'(rd && !wr));
        else n_pass++;
      end
      n_chk++;
      if (o.rdata !== last_rdata) $display("FAIL rnd_rdata%0d: got %h want %h", t, o.rdata, last_rdata);
      else n_pass++;
      n_chk++;
      if (!o.done) $display("FAIL rnd_timeout%0d: got no completion want completion", t);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load_ext();
    test_watchdog();
    test_conflict_and_buserr();
    test_async_reset();
    test_misalign();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
